// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: ARM-subset decode stage with register file, hazard detection and ID/EX register
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   i_in_valid                    i_instruction / i_pc_in carry a real instruction
//   i_instruction, i_pc_in        instruction word and its PC
//   i_status                      {N,Z,C,V} flags used for the condition check
//   i_stall_in                    hold the ID/EX contents
//   i_flush                       replace the ID/EX contents with a bubble
//   i_wb_en/_dest/_value          register file write port
//   i_exe_wb_en/_dest             writer currently in EX
//   i_mem_wb_en/_dest             writer currently in MEM
//   o_hazard_out                  combinational RAW hazard back to IF
//   o_ex_*                        registered decode results for EX
module id_stage_pipelined #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int PC_W      = 32,
    parameter int BYPASS_EN = 1,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    input  logic [31:0]       i_instruction,
    input  logic [PC_W-1:0]   i_pc_in,
    input  logic [3:0]        i_status,
    input  logic              i_stall_in,
    input  logic              i_flush,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_dest,
    input  logic [DATA_W-1:0] i_wb_value,
    input  logic              i_exe_wb_en,
    input  logic [REG_AW-1:0] i_exe_dest,
    input  logic              i_mem_wb_en,
    input  logic [REG_AW-1:0] i_mem_dest,
    output logic              o_hazard_out,
    output logic              o_ex_valid,
    output logic              o_ex_wb_en,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic              o_ex_branch,
    output logic              o_ex_s,
    output logic              o_ex_imm,
    output logic [3:0]        o_ex_cmd,
    output logic [REG_AW-1:0] o_ex_dest,
    output logic [REG_AW-1:0] o_ex_src1,
    output logic [REG_AW-1:0] o_ex_src2,
    output logic [DATA_W-1:0] o_ex_val_rn,
    output logic [DATA_W-1:0] o_ex_val_rm,
    output logic [11:0]       o_ex_shift,
    output logic [23:0]       o_ex_simm24,
    output logic [PC_W-1:0]   o_ex_pc
);
    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              s;
        logic              imm;
        logic [3:0]        cmd;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [11:0]       shift;
        logic [23:0]       simm24;
        logic [PC_W-1:0]   pc;
    } ex_t;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    ex_t               r_ex;
    ex_t               w_dec;
    logic [3:0]        w_cond;
    logic [1:0]        w_mode;
    logic [3:0]        w_op;
    logic              w_sbit;
    logic              w_ibit;
    logic [REG_AW-1:0] w_rn;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rm;
    logic [REG_AW-1:0] w_src2;
    logic              w_m00;
    logic              w_m01;
    logic              w_m10;
    logic              w_str;
    logic              w_cond_ok;
    logic [5:0]        w_alu;
    logic              w_uses_rn;
    logic              w_uses_rm;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic [DATA_W-1:0] w_val_rn;
    logic [DATA_W-1:0] w_val_rm;

    assign w_cond = i_instruction[31:28];
    assign w_mode = i_instruction[27:26];
    assign w_ibit = i_instruction[25];
    assign w_op   = i_instruction[24:21];
    assign w_sbit = i_instruction[20];
    assign w_rn   = i_instruction[16 +: REG_AW];
    assign w_rd   = i_instruction[12 +: REG_AW];
    assign w_rm   = i_instruction[0 +: REG_AW];
    assign w_m00  = w_mode == 2'b00;
    assign w_m01  = w_mode == 2'b01;
    assign w_m10  = w_mode == 2'b10;
    assign w_str  = w_m01 & ~w_sbit;
    // STR reads its store data from the Rd field
    assign w_src2 = w_str ? w_rd : w_rm;
    assign {w_n, w_z, w_c, w_v} = i_status;

    always_comb begin
        case (w_cond)
            4'h0:    w_cond_ok = w_z;
            4'h1:    w_cond_ok = ~w_z;
            4'h2:    w_cond_ok = w_c;
            4'h3:    w_cond_ok = ~w_c;
            4'h4:    w_cond_ok = w_n;
            4'h5:    w_cond_ok = ~w_n;
            4'h6:    w_cond_ok = w_v;
            4'h7:    w_cond_ok = ~w_v;
            4'h8:    w_cond_ok = w_c & ~w_z;
            4'h9:    w_cond_ok = ~w_c | w_z;
            4'hA:    w_cond_ok = w_n == w_v;
            4'hB:    w_cond_ok = w_n != w_v;
            4'hC:    w_cond_ok = ~w_z & (w_n == w_v);
            4'hD:    w_cond_ok = w_z | (w_n != w_v);
            4'hE:    w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // {defined, cmd, wb} for data-processing opcodes
    always_comb begin
        case (w_op)
            4'b1101: w_alu = 6'b1_0001_1;
            4'b1111: w_alu = 6'b1_1001_1;
            4'b0100: w_alu = 6'b1_0010_1;
            4'b0101: w_alu = 6'b1_0011_1;
            4'b0010: w_alu = 6'b1_0100_1;
            4'b0110: w_alu = 6'b1_0101_1;
            4'b0000: w_alu = 6'b1_0110_1;
            4'b1100: w_alu = 6'b1_0111_1;
            4'b0001: w_alu = 6'b1_1000_1;
            4'b1010: w_alu = 6'b1_0100_0;
            4'b1000: w_alu = 6'b1_0110_0;
            default: w_alu = 6'b0_0000_0;
        endcase
    end

    assign w_uses_rn = (w_m00 & w_op != 4'b1101 & w_op != 4'b1111) | w_m01;
    assign w_uses_rm = (w_m00 & ~w_ibit) | w_str;
    assign o_hazard_out = i_in_valid &
        ((w_uses_rn & ((i_exe_wb_en & i_exe_dest == w_rn) | (i_mem_wb_en & i_mem_dest == w_rn))) |
         (w_uses_rm & ((i_exe_wb_en & i_exe_dest == w_src2) | (i_mem_wb_en & i_mem_dest == w_src2))));

    assign w_val_rn = (BYPASS_EN != 0 && i_wb_en && i_wb_dest == w_rn) ? i_wb_value : r_regs[w_rn];
    assign w_val_rm = (BYPASS_EN != 0 && i_wb_en && i_wb_dest == w_src2) ? i_wb_value : r_regs[w_src2];

    // a failed condition or undefined encoding leaves every enable and the command at zero
    assign w_dec = '{
        valid:     1'b1,
        wb_en:     w_cond_ok & ((w_m00 & w_alu[0]) | (w_m01 & w_sbit)),
        mem_read:  w_cond_ok & w_m01 & w_sbit,
        mem_write: w_cond_ok & w_str,
        branch:    w_cond_ok & w_m10,
        s:         w_cond_ok & w_m00 & w_alu[5] & w_sbit,
        imm:       w_ibit,
        cmd:       ~w_cond_ok ? 4'b0000 : w_m00 ? w_alu[4:1] : w_m01 ? 4'b0010 : 4'b0000,
        dest:      w_rd,
        src1:      w_rn,
        src2:      w_src2,
        val_rn:    w_val_rn,
        val_rm:    w_val_rm,
        shift:     i_instruction[11:0],
        simm24:    i_instruction[23:0],
        pc:        i_pc_in
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        else if (i_wb_en)
            r_regs[i_wb_dest] <= i_wb_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ex <= '0;
        else if (i_flush)
            r_ex <= '0;
        else if (!i_stall_in)
            r_ex <= (o_hazard_out || !i_in_valid) ? '0 : w_dec;
    end

    assign o_ex_valid     = r_ex.valid;
    assign o_ex_wb_en     = r_ex.wb_en;
    assign o_ex_mem_read  = r_ex.mem_read;
    assign o_ex_mem_write = r_ex.mem_write;
    assign o_ex_branch    = r_ex.branch;
    assign o_ex_s         = r_ex.s;
    assign o_ex_imm       = r_ex.imm;
    assign o_ex_cmd       = r_ex.cmd;
    assign o_ex_dest      = r_ex.dest;
    assign o_ex_src1      = r_ex.src1;
    assign o_ex_src2      = r_ex.src2;
    assign o_ex_val_rn    = r_ex.val_rn;
    assign o_ex_val_rm    = r_ex.val_rm;
    assign o_ex_shift     = r_ex.shift;
    assign o_ex_simm24    = r_ex.simm24;
    assign o_ex_pc        = r_ex.pc;
endmodule
